// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 load/store sizes, result source,
// and the state type for the data-memory access sequencer.
package riscv_pkg;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // An access faults on an unsupported funct3 or a size-misaligned byte address.
    function automatic logic access_faults(input logic isStore, input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic legal;
        logic misaligned;
        if (isStore) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                     ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = 8'h00;
        case (addr_i)
            2'b00:   byteSel = word_i[7:0];
            2'b01:   byteSel = word_i[15:8];
            2'b10:   byteSel = word_i[23:16];
            default: byteSel = word_i[31:24];
        endcase
        halfSel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = word_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            F3_LBU:  data_o = {24'h000000, byteSel};
            F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            F3_LHU:  data_o = {16'h0000, halfSel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage sequencer: turns a load/store in EX/MEM into a valid/ready request,
// stalls the pipeline until it completes, and returns extended load data.
module mem_access
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  result_src_m_i,
    input  logic        mem_write_m_i,
    input  logic [31:0] alu_result_m_i,
    input  logic [31:0] write_data_m_i,
    input  logic [2:0]  funct3_m_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        req_we_o,
    output logic [31:0] req_addr_o,
    output logic [31:0] req_wdata_o,
    output logic [3:0]  req_be_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_rdata_i,
    output logic        stall_o,
    output logic [31:0] read_data_m_o,
    output logic        access_fault_o
);

    mem_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;

    logic        isLoad;
    logic        accessValid;
    logic        isFault;
    logic [31:0] extData;

    assign isLoad      = (result_src_m_i == RESULT_SRC_LOAD);
    assign accessValid = isLoad || mem_write_m_i;
    assign isFault     = access_faults(mem_write_m_i, funct3_m_i, alu_result_m_i[1:0]);

    load_extend u_load_extend (
        .word_i   (rsp_rdata_i),
        .addr_i   (offset_q),
        .funct3_i (funct3_q),
        .data_o   (extData)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        be_d           = be_q;
        we_d           = we_q;
        funct3_d       = funct3_q;
        offset_d       = offset_q;
        stall_o        = 1'b0;
        access_fault_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (accessValid) begin
                    if (isFault) begin
                        access_fault_o = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        addr_d   = {alu_result_m_i[31:2], 2'b00};
                        we_d     = mem_write_m_i;
                        funct3_d = funct3_m_i;
                        offset_d = alu_result_m_i[1:0];
                        // Store lanes are replicated so the byte-enables alone pick the target.
                        case (funct3_m_i[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << alu_result_m_i[1:0];
                                wdata_d = {4{write_data_m_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << alu_result_m_i[1:0];
                                wdata_d = {2{write_data_m_i[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = write_data_m_i;
                            end
                        endcase
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (req_ready_i) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (rsp_valid_i) begin
                    rdata_d = extData;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_valid_o   = (state_q == REQ);
    assign req_we_o      = we_q;
    assign req_addr_o    = addr_q;
    assign req_wdata_o   = wdata_q;
    assign req_be_o      = be_q;
    assign read_data_m_o = rdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a transaction-level
// model of the request/response timeline and load/store lane rules.
module tb_mem_access;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  result_src_m_i = '0;
    logic        mem_write_m_i = 1'b0;
    logic [31:0] alu_result_m_i = '0;
    logic [31:0] write_data_m_i = '0;
    logic [2:0]  funct3_m_i = '0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic        req_we_o;
    logic [31:0] req_addr_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_be_o;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_rdata_i = '0;
    logic        stall_o;
    logic [31:0] read_data_m_o;
    logic        access_fault_o;

    mem_access dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .result_src_m_i (result_src_m_i),
        .mem_write_m_i  (mem_write_m_i),
        .alu_result_m_i (alu_result_m_i),
        .write_data_m_i (write_data_m_i),
        .funct3_m_i     (funct3_m_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_we_o       (req_we_o),
        .req_addr_o     (req_addr_o),
        .req_wdata_o    (req_wdata_o),
        .req_be_o       (req_be_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_rdata_i    (rsp_rdata_i),
        .stall_o        (stall_o),
        .read_data_m_o  (read_data_m_o),
        .access_fault_o (access_fault_o)
    );

    always #5 clk_i = ~clk_i;

    int testsRun = 0;
    int testsFailed = 0;

    logic        checkEn = 1'b0;
    logic        expStall = 1'b0;
    logic        expValid = 1'b0;
    logic        expFault = 1'b0;
    logic        expWe = 1'b0;
    logic [31:0] expAddr = '0;
    logic [3:0]  expBe = '0;
    logic [31:0] expWdata = '0;
    logic [31:0] expReadData = '0;

    int          stallCount = 0;
    int          handshakeCount = 0;
    logic        validSeen = 1'b0;
    logic [31:0] lastAddr = '0;
    logic [3:0]  lastBe = '0;
    logic [31:0] lastWdata = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an access faults on unsupported funct3 or an address not a multiple of its size.
    function automatic logic modelFault(input logic isStore, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        int   sizeBytes;
        legal = isStore ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sizeBytes = 1 << (f3 % 4);
        return !legal || ((off % sizeBytes) != 0);
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [1:0] off);
        case (f3 % 4)
            0:       return 4'(1 << off);
            1:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3 % 4)
            0:       return (wd & 32'hFF) * 32'h01010101;
            1:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (checkEn) begin
            checkOutput("stall_o", 32'(stall_o), 32'(expStall));
            checkOutput("req_valid_o", 32'(req_valid_o), 32'(expValid));
            checkOutput("access_fault_o", 32'(access_fault_o), 32'(expFault));
            checkOutput("read_data_m_o", read_data_m_o, expReadData);
            if (expValid) begin
                checkOutput("req_addr_o", req_addr_o, expAddr);
                checkOutput("req_we_o", 32'(req_we_o), 32'(expWe));
                if (expWe) begin
                    checkOutput("req_be_o", 32'(req_be_o), 32'(expBe));
                    checkOutput("req_wdata_o", req_wdata_o, expWdata);
                end
            end
            if (stall_o) stallCount++;
            if (req_valid_o && req_ready_i) handshakeCount++;
            if (req_valid_o) begin
                validSeen = 1'b1;
                lastAddr  = req_addr_o;
                lastBe    = req_be_o;
                lastWdata = req_wdata_o;
            end
        end
    end

    // One instruction in EX/MEM, held while stalled, with ready/response delays in cycles.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int rdyDly, input int rspDly, input logic [31:0] rword);
        logic access;
        logic flt;
        logic [1:0] off;
        access = ld || st;
        off = addr[1:0];
        flt = access && modelFault(st, f3, off);
        stallCount = 0;
        handshakeCount = 0;
        validSeen = 1'b0;

        @(posedge clk_i); #1;
        case ($urandom_range(0, 2))
            0:       result_src_m_i = 2'b00;
            1:       result_src_m_i = 2'b10;
            default: result_src_m_i = 2'b11;
        endcase
        if (ld) result_src_m_i = 2'b01;
        mem_write_m_i  = st;
        alu_result_m_i = addr;
        write_data_m_i = wd;
        funct3_m_i     = f3;
        req_ready_i    = 1'($urandom % 2);
        rsp_valid_i    = 1'($urandom % 2);
        rsp_rdata_i    = $urandom;
        expValid = 1'b0;
        expFault = flt;
        expStall = access && !flt;
        if (!access || flt) return;

        expAddr  = {addr[31:2], 2'b00};
        expWe    = st;
        expBe    = modelBe(f3, off);
        expWdata = modelWdata(f3, wd);

        for (int i = 0; i <= rdyDly; i++) begin
            @(posedge clk_i); #1;
            req_ready_i = (i == rdyDly);
            rsp_valid_i = 1'($urandom % 2);
            rsp_rdata_i = $urandom;
            expValid = 1'b1;
            expStall = 1'b1;
            expFault = 1'b0;
        end
        if (!st) begin
            for (int j = 0; j <= rspDly; j++) begin
                @(posedge clk_i); #1;
                req_ready_i = 1'($urandom % 2);
                rsp_valid_i = (j == rspDly);
                rsp_rdata_i = (j == rspDly) ? rword : $urandom;
                expValid = 1'b0;
                expStall = 1'b1;
            end
        end
        @(posedge clk_i); #1;
        req_ready_i = 1'($urandom % 2);
        rsp_valid_i = 1'($urandom % 2);
        rsp_rdata_i = $urandom;
        expValid = 1'b0;
        expStall = 1'b0;
        if (!st) expReadData = modelLoad(rword, off, f3);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [2:0] f3;
        logic       ld;
        logic       st;
        int         kind;

        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset req_valid_o", 32'(req_valid_o), 32'd0);
        checkOutput("reset req_we_o", 32'(req_we_o), 32'd0);
        checkOutput("reset req_addr_o", req_addr_o, 32'd0);
        checkOutput("reset req_wdata_o", req_wdata_o, 32'd0);
        checkOutput("reset req_be_o", 32'(req_be_o), 32'd0);
        checkOutput("reset read_data_m_o", read_data_m_o, 32'd0);
        checkOutput("reset access_fault_o", 32'(access_fault_o), 32'd0);
        checkOutput("reset stall_o", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        checkEn = 1'b1;

        applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        @(negedge clk_i);
        checkOutput("SW req_addr", lastAddr, 32'h100);
        checkOutput("SW be", 32'(lastBe), 32'hF);
        checkOutput("SW wdata", lastWdata, 32'hDEADBEEF);
        checkOutput("SW stall cycles", stallCount, 2);
        checkOutput("SW handshakes", handshakeCount, 1);

        applyStimulus(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FFFF00);
        @(negedge clk_i);
        checkOutput("LB read_data", read_data_m_o, 32'hFFFFFF80);
        checkOutput("LB stall cycles", stallCount, 3);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80FFFF00);
        @(negedge clk_i);
        checkOutput("LBU read_data", read_data_m_o, 32'h00000080);

        applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0);
        @(negedge clk_i);
        checkOutput("SH be", 32'(lastBe), 32'hC);
        checkOutput("SH wdata", lastWdata, 32'hABCDABCD);

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
        @(negedge clk_i);
        checkOutput("LW misaligned fault", 32'(access_fault_o), 32'd1);
        checkOutput("LW misaligned stall", 32'(stall_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk_i);
        checkOutput("LW misaligned no request", 32'(validSeen), 32'd0);
        checkOutput("LBU data held", read_data_m_o, 32'h00000080);

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 3, 2, 32'hCAFEF00D);
        @(negedge clk_i);
        checkOutput("LW slow handshakes", handshakeCount, 1);
        checkOutput("LW slow stall cycles", stallCount, 8);
        checkOutput("LW slow read_data", read_data_m_o, 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            ld = (kind >= 1 && kind <= 3) || kind == 7;
            st = (kind >= 4);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            applyStimulus(ld, st, f3, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk_i);
        checkEn = 1'b0;
        @(posedge clk_i); #1;
        result_src_m_i = 2'b01;
        mem_write_m_i  = 1'b0;
        alu_result_m_i = 32'h300;
        funct3_m_i     = 3'b010;
        req_ready_i    = 1'b0;
        rsp_valid_i    = 1'b0;
        @(posedge clk_i); #1;
        req_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("abort req_valid", 32'(req_valid_o), 32'd1);
        @(posedge clk_i); #1;
        req_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("abort in wait stall", 32'(stall_o), 32'd1);
        checkOutput("abort in wait req_valid", 32'(req_valid_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        result_src_m_i = 2'b00;
        rsp_valid_i = 1'b1;
        rsp_rdata_i = 32'hFFFFFFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checkOutput("abort stall", 32'(stall_o), 32'd0);
            checkOutput("abort req_valid", 32'(req_valid_o), 32'd0);
            checkOutput("abort read_data", read_data_m_o, 32'd0);
            @(posedge clk_i); #1;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
